// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding fetches to instruction
// memory and presents one instruction at a time to Control over a valid/ready handshake.
`timescale 1ns/1ps

module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        memRequest,
  output logic [31:0] memAddress,
  input  logic        memGrant,
  input  logic        memDataValid,
  input  logic [31:0] memReadData,
  output logic [31:0] instructionData,
  output logic        instructionValid,
  output logic [31:0] instructionPC,
  output logic [31:0] nextPCAddress,
  input  logic        decodeReady,
  input  logic        redirect,
  input  logic [31:0] redirectTarget
);

  localparam int unsigned XLEN          = 32;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

  typedef enum logic {
    S_REQUEST = 1'b0,
    S_WAIT    = 1'b1
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_discard;
  logic            r_live;
  logic [XLEN-1:0] r_instr_data;
  logic            r_instr_valid;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] r_next_pc;

  logic w_transfer;
  logic w_issue;
  logic w_granted;
  logic w_load;

  // A request goes out only when the output register can take the response; r_live keeps
  // it low until the first edge after reset release.
  assign w_transfer = r_instr_valid && decodeReady;
  assign w_issue    = r_live && (r_state == S_REQUEST) && (!r_instr_valid || decodeReady);
  assign w_granted  = w_issue && memGrant;
  assign w_load     = (r_state == S_WAIT) && memDataValid && !r_discard && !redirect;

  assign memRequest       = w_issue;
  assign memAddress       = r_pc;
  assign instructionData  = r_instr_data;
  assign instructionValid = r_instr_valid;
  assign instructionPC    = r_instr_pc;
  assign nextPCAddress    = r_next_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_REQUEST;
      r_pc          <= RESET_PC;
      r_discard     <= 1'b0;
      r_live        <= 1'b0;
      r_instr_data  <= '0;
      r_instr_valid <= 1'b0;
      r_instr_pc    <= '0;
      r_next_pc     <= '0;
    end else begin
      r_live <= 1'b1;

      // Output register: reload wins over transfer; a redirect flushes it.
      if (w_load) begin
        r_instr_data  <= memReadData;
        r_instr_valid <= 1'b1;
        r_instr_pc    <= r_pc;
        r_next_pc     <= r_pc + PC_STEP;
      end else if (w_transfer || redirect) begin
        r_instr_data  <= '0;
        r_instr_valid <= 1'b0;
      end

      if (redirect) begin
        r_pc <= redirectTarget & ALIGN_MSK;
        if (w_granted) begin
          r_state   <= S_WAIT;
          r_discard <= 1'b1;
        end else if ((r_state == S_WAIT) && !memDataValid) begin
          r_discard <= 1'b1;
        end else begin
          r_state   <= S_REQUEST;
          r_discard <= 1'b0;
        end
      end else begin
        case (r_state)
          S_REQUEST: begin
            if (w_granted) begin
              r_state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (memDataValid) begin
              r_state   <= S_REQUEST;
              r_discard <= 1'b0;
              if (!r_discard) begin
                r_pc <= r_pc + PC_STEP;
              end
            end
          end
          default: r_state <= S_REQUEST;
        endcase
      end
    end
  end

endmodule
